// File: rtl/iommu_pdtc_sa.sv
// iommu_pdtc_sa -- set-associative Process Directory Table Cache.
//
// Caches process contexts (iommu_pkg::pc_t) tagged by {device_id, process_id}.
// Set index = low bits of (pid ^ did). Each set has a tree PLRU.
// Lookups are registered and return one cycle after they are accepted.
// A DID-only invalidation sweeps one set per cycle and raises busy_o.
//
// Ports
//   clk_i, rst_i                   clock, synchronous active-high reset
//   flush_i, flush_dv_i,           invalidation request and match mode
//   flush_pv_i, flush_did_i,
//   flush_pid_i
//   busy_o                         DID sweep in progress
//   update_i, up_did_i, up_pid_i,  insert request (dropped unless ta.v=1)
//   up_content_i
//   lookup_i, lu_did_i, lu_pid_i   lookup request
//   lu_valid_o, lu_hit_o,          registered lookup result
//   lu_content_o
//
// Optional feature (macro IOMMU_PDTC_PERF_EN): adds perf_clr_i, hit_cnt_o and
// miss_cnt_o, saturating 32-bit counters of accepted lookups.

package iommu_pkg;
  typedef struct packed {
    logic [19:0] pscid;
    logic        sum;
    logic        ens;
    logic        v;
  } ta_t;

  typedef struct packed {
    logic [3:0]  mode;
    logic [43:0] ppn;
  } fsc_t;

  typedef struct packed {
    ta_t  ta;
    fsc_t fsc;
  } pc_t;
endpackage

module iommu_pdtc_sa #(
  parameter int unsigned SETS             = 4,
  parameter int unsigned WAYS             = 4,
  parameter int unsigned DEVICE_ID_WIDTH  = 24,
  parameter int unsigned PROCESS_ID_WIDTH = 20
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_i,
  input  logic                        flush_dv_i,
  input  logic                        flush_pv_i,
  input  logic [DEVICE_ID_WIDTH-1:0]  flush_did_i,
  input  logic [PROCESS_ID_WIDTH-1:0] flush_pid_i,
  output logic                        busy_o,
  input  logic                        update_i,
  input  logic [DEVICE_ID_WIDTH-1:0]  up_did_i,
  input  logic [PROCESS_ID_WIDTH-1:0] up_pid_i,
  input  iommu_pkg::pc_t              up_content_i,
  input  logic                        lookup_i,
  input  logic [DEVICE_ID_WIDTH-1:0]  lu_did_i,
  input  logic [PROCESS_ID_WIDTH-1:0] lu_pid_i,
  output logic                        lu_valid_o,
  output logic                        lu_hit_o,
  output iommu_pkg::pc_t              lu_content_o
`ifdef IOMMU_PDTC_PERF_EN
  ,
  input  logic                        perf_clr_i,
  output logic [31:0]                 hit_cnt_o,
  output logic [31:0]                 miss_cnt_o
`endif
);

  localparam int unsigned SW = (SETS > 1) ? $clog2(SETS) : 1;
  localparam int unsigned WW = $clog2(WAYS);

  typedef logic [SW-1:0]   set_t;
  typedef logic [WW-1:0]   way_t;
  typedef logic [WAYS-2:0] plru_t;

  typedef enum logic {IDLE, SWEEP} state_t;

  logic [DEVICE_ID_WIDTH-1:0]  did_q  [SETS][WAYS];
  logic [PROCESS_ID_WIDTH-1:0] pid_q  [SETS][WAYS];
  iommu_pkg::pc_t              data_q [SETS][WAYS];
  logic [WAYS-1:0]             valid_q [SETS];
  plru_t                       plru_q  [SETS];

  state_t                      state;
  set_t                        sweep_idx;
  logic [DEVICE_ID_WIDTH-1:0]  sweep_did;

  function automatic set_t set_idx(input logic [DEVICE_ID_WIDTH-1:0]  did,
                                   input logic [PROCESS_ID_WIDTH-1:0] pid);
    if (SETS == 1) return '0;
    return set_t'(did[SW-1:0] ^ pid[SW-1:0]);
  endfunction

  // Tree PLRU, heap-numbered nodes 1..WAYS-1 stored at bit node-1.
  // Each node bit points toward the subtree to evict next.
  function automatic plru_t plru_touch(input plru_t bits, input way_t way);
    plru_t r;
    way_t  node;
    way_t  rest;
    logic  b;
    r    = bits;
    node = way_t'(1);
    rest = way;
    for (int unsigned l = 0; l < WW; l++) begin
      b                   = rest[WW-1];
      r[node - way_t'(1)] = ~b;
      node                = way_t'({node, b});
      rest                = rest << 1;
    end
    return r;
  endfunction

  function automatic way_t plru_victim(input plru_t bits);
    way_t node;
    way_t v;
    logic b;
    node = way_t'(1);
    v    = '0;
    for (int unsigned l = 0; l < WW; l++) begin
      b    = bits[node - way_t'(1)];
      v    = way_t'({v, b});
      node = way_t'({node, b});
    end
    return v;
  endfunction

  set_t lu_set, up_set, fl_set;
  logic lu_acc, up_acc, fl_acc;
  logic lu_hit;
  way_t lu_way;
  logic up_same, up_free;
  way_t up_same_way, up_free_way, up_way;
  logic [WAYS-1:0] fl_mask, sw_mask;

  assign lu_set = set_idx(lu_did_i, lu_pid_i);
  assign up_set = set_idx(up_did_i, up_pid_i);
  assign fl_set = set_idx(flush_did_i, flush_pid_i);

  assign lu_acc = lookup_i && !busy_o && !flush_i;
  assign up_acc = update_i && !busy_o && !flush_i && up_content_i.ta.v;
  assign fl_acc = flush_i && !busy_o;

  always_comb begin
    lu_hit = 1'b0;
    lu_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[lu_set][w] && did_q[lu_set][w] == lu_did_i &&
          pid_q[lu_set][w] == lu_pid_i) begin
        lu_hit = 1'b1;
        lu_way = way_t'(w);
      end
    end
  end

  // Way choice: overwrite same tag, else lowest free way, else PLRU victim.
  always_comb begin
    up_same     = 1'b0;
    up_same_way = '0;
    up_free     = 1'b0;
    up_free_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[up_set][w] && did_q[up_set][w] == up_did_i &&
          pid_q[up_set][w] == up_pid_i) begin
        up_same     = 1'b1;
        up_same_way = way_t'(w);
      end
      if (!valid_q[up_set][w] && !up_free) begin
        up_free     = 1'b1;
        up_free_way = way_t'(w);
      end
    end
    if (up_same)      up_way = up_same_way;
    else if (up_free) up_way = up_free_way;
    else              up_way = plru_victim(plru_q[up_set]);
  end

  always_comb begin
    fl_mask = '0;
    sw_mask = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      fl_mask[w] = did_q[fl_set][w] == flush_did_i && pid_q[fl_set][w] == flush_pid_i;
      sw_mask[w] = did_q[sweep_idx][w] == sweep_did;
    end
  end

  // Tag/data storage carries no reset; valid bits gate every use.
  always_ff @(posedge clk_i) begin
    if (up_acc) begin
      did_q[up_set][up_way]  <= up_did_i;
      pid_q[up_set][up_way]  <= up_pid_i;
      data_q[up_set][up_way] <= up_content_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      busy_o       <= 1'b0;
      sweep_idx    <= '0;
      sweep_did    <= '0;
      lu_valid_o   <= 1'b0;
      lu_hit_o     <= 1'b0;
      lu_content_o <= '0;
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      lu_valid_o   <= lu_acc;
      lu_hit_o     <= lu_acc && lu_hit;
      lu_content_o <= (lu_acc && lu_hit) ? data_q[lu_set][lu_way] : '0;

      // Update touch is issued last so it wins when both hit the same set.
      if (lu_acc && lu_hit) plru_q[lu_set] <= plru_touch(plru_q[lu_set], lu_way);
      if (up_acc)           plru_q[up_set] <= plru_touch(plru_q[up_set], up_way);

      if (up_acc) valid_q[up_set][up_way] <= 1'b1;

      case (state)
        IDLE: begin
          if (fl_acc) begin
            if (flush_pv_i) begin
              valid_q[fl_set] <= valid_q[fl_set] & ~fl_mask;
            end else if (flush_dv_i) begin
              state     <= SWEEP;
              busy_o    <= 1'b1;
              sweep_idx <= '0;
              sweep_did <= flush_did_i;
            end else begin
              for (int unsigned s = 0; s < SETS; s++) valid_q[s] <= '0;
            end
          end
        end
        SWEEP: begin
          valid_q[sweep_idx] <= valid_q[sweep_idx] & ~sw_mask;
          if (sweep_idx == set_t'(SETS - 1)) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            sweep_idx <= sweep_idx + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef IOMMU_PDTC_PERF_EN
  always_ff @(posedge clk_i) begin
    if (rst_i || perf_clr_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (lu_acc) begin
      if (lu_hit) begin
        if (hit_cnt_o != '1) hit_cnt_o <= hit_cnt_o + 32'd1;
      end else begin
        if (miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_iommu_pdtc_sa.sv
// tb_iommu_pdtc_sa -- scoreboard bench for iommu_pdtc_sa (SETS=4, WAYS=2).
// The reference model keeps the cache as a map of tags to contexts plus a
// global recency list; a full set evicts its least recently touched tag.
module tb_iommu_pdtc_sa;
  import iommu_pkg::*;

  localparam int unsigned SETS = 4;
  localparam int unsigned WAYS = 2;
  localparam int unsigned DIDW = 24;
  localparam int unsigned PIDW = 20;

  typedef logic [DIDW+PIDW-1:0] key_t;
  typedef struct packed { logic hit; pc_t content; } exp_t;
  typedef struct packed {
    logic lk; logic [DIDW-1:0] ld; logic [PIDW-1:0] lp;
    logic up; logic [DIDW-1:0] ud; logic [PIDW-1:0] upp; pc_t uc;
    logic fl; logic fdv; logic fpv; logic [DIDW-1:0] fd; logic [PIDW-1:0] fp;
    logic clr;
  } op_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush, flush_dv, flush_pv;
  logic [DIDW-1:0] flush_did;
  logic [PIDW-1:0] flush_pid;
  logic            busy;
  logic            update;
  logic [DIDW-1:0] up_did;
  logic [PIDW-1:0] up_pid;
  pc_t             up_content;
  logic            lookup;
  logic [DIDW-1:0] lu_did;
  logic [PIDW-1:0] lu_pid;
  logic            lu_valid, lu_hit;
  pc_t             lu_content;
`ifdef IOMMU_PDTC_PERF_EN
  logic            perf_clr;
  logic [31:0]     hit_cnt, miss_cnt;
  logic [31:0]     m_hit, m_miss;
`endif

  iommu_pdtc_sa #(
    .SETS(SETS), .WAYS(WAYS), .DEVICE_ID_WIDTH(DIDW), .PROCESS_ID_WIDTH(PIDW)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .flush_i(flush), .flush_dv_i(flush_dv), .flush_pv_i(flush_pv),
    .flush_did_i(flush_did), .flush_pid_i(flush_pid), .busy_o(busy),
    .update_i(update), .up_did_i(up_did), .up_pid_i(up_pid), .up_content_i(up_content),
    .lookup_i(lookup), .lu_did_i(lu_did), .lu_pid_i(lu_pid),
    .lu_valid_o(lu_valid), .lu_hit_o(lu_hit), .lu_content_o(lu_content)
`ifdef IOMMU_PDTC_PERF_EN
    , .perf_clr_i(perf_clr), .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  exp_t        exp_q[$];
  key_t        rec_q[$];
  pc_t         mem_m[key_t];
  int unsigned busy_cnt = 0;

  function automatic int unsigned set_of(input key_t k);
    logic [1:0] s;
    s = k[PIDW +: 2] ^ k[1:0];
    return int'(s);
  endfunction

  function automatic int find_key(input key_t k);
    foreach (rec_q[i]) if (rec_q[i] == k) return i;
    return -1;
  endfunction

  function automatic void touch(input key_t k);
    int i;
    i = find_key(k);
    if (i >= 0) rec_q.delete(i);
    rec_q.push_back(k);
  endfunction

  function automatic void drop(input key_t k);
    int i;
    i = find_key(k);
    if (i >= 0) rec_q.delete(i);
    if (mem_m.exists(k)) mem_m.delete(k);
  endfunction

  function automatic void insert(input key_t k, input pc_t c);
    int unsigned cnt;
    key_t        victim;
    logic        found;
    if (!mem_m.exists(k)) begin
      cnt    = 0;
      found  = 1'b0;
      victim = '0;
      foreach (rec_q[i]) begin
        if (set_of(rec_q[i]) == set_of(k)) begin
          cnt++;
          if (!found) begin
            victim = rec_q[i];
            found  = 1'b1;
          end
        end
      end
      if (cnt == WAYS) drop(victim);
    end
    mem_m[k] = c;
    touch(k);
  endfunction

  function automatic pc_t mk_pc(input logic v);
    logic [95:0] r;
    pc_t         c;
    r      = {$urandom(), $urandom(), $urandom()};
    c      = pc_t'(r);
    c.ta.v = v;
    return c;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (lu_valid) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL lu_unexpected: lu_valid_o=1 with no lookup outstanding (hit=%0b)", lu_hit);
      end else begin
        e = exp_q.pop_front();
        if (lu_hit !== e.hit || lu_content !== e.content) begin
          fails++;
          $display("FAIL lookup: got hit=%0b content=%h, expected hit=%0b content=%h",
                   lu_hit, lu_content, e.hit, e.content);
        end
      end
    end
  end

  task automatic step(input op_t o);
    logic mbusy;
    key_t k;
    exp_t e;
    mbusy = busy_cnt != 0;
    tests++;
    if (busy !== mbusy) begin
      fails++;
      $display("FAIL busy: got %0b, expected %0b", busy, mbusy);
    end
    tests++;
    if (exp_q.size() > 1) begin
      fails++;
      $display("FAIL lu_missing: %0d results outstanding, expected at most 1", exp_q.size());
    end
`ifdef IOMMU_PDTC_PERF_EN
    tests++;
    if (hit_cnt !== m_hit || miss_cnt !== m_miss) begin
      fails++;
      $display("FAIL perf_cnt: got hit=%0d miss=%0d, expected hit=%0d miss=%0d",
               hit_cnt, miss_cnt, m_hit, m_miss);
    end
    perf_clr = o.clr;
`endif
    lookup = o.lk; lu_did = o.ld; lu_pid = o.lp;
    update = o.up; up_did = o.ud; up_pid = o.upp; up_content = o.uc;
    flush = o.fl; flush_dv = o.fdv; flush_pv = o.fpv; flush_did = o.fd; flush_pid = o.fp;

    if (o.lk && !mbusy && !o.fl) begin
      k = {o.ld, o.lp};
      if (mem_m.exists(k)) begin
        e.hit = 1'b1; e.content = mem_m[k];
        touch(k);
      end else begin
        e = '0;
      end
`ifdef IOMMU_PDTC_PERF_EN
      if (e.hit) m_hit++; else m_miss++;
`endif
      exp_q.push_back(e);
    end
`ifdef IOMMU_PDTC_PERF_EN
    if (o.clr) begin m_hit = 0; m_miss = 0; end
`endif
    if (o.up && !mbusy && !o.fl && o.uc.ta.v) insert({o.ud, o.upp}, o.uc);
    if (busy_cnt != 0) busy_cnt--;
    if (o.fl && !mbusy) begin
      if (o.fpv) begin
        drop({o.fd, o.fp});
      end else if (o.fdv) begin
        for (int i = rec_q.size() - 1; i >= 0; i--) begin
          if (rec_q[i][PIDW +: DIDW] == o.fd) begin
            mem_m.delete(rec_q[i]);
            rec_q.delete(i);
          end
        end
        busy_cnt = SETS;
      end else begin
        rec_q.delete();
        mem_m.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    op_t z;
    z = '0;
    rst = 1'b1;
    lookup = 1'b0; update = 1'b0; flush = 1'b0; flush_dv = 1'b0; flush_pv = 1'b0;
    lu_did = '0; lu_pid = '0; up_did = '0; up_pid = '0; up_content = '0;
    flush_did = '0; flush_pid = '0;
`ifdef IOMMU_PDTC_PERF_EN
    perf_clr = 1'b0;
    m_hit = 0; m_miss = 0;
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    rec_q.delete(); mem_m.delete(); exp_q.delete(); busy_cnt = 0;
    tests++;
    if (busy !== 1'b0 || lu_valid !== 1'b0 || lu_hit !== 1'b0 || lu_content !== pc_t'(0)) begin
      fails++;
      $display("FAIL reset_state: busy=%0b lu_valid=%0b lu_hit=%0b content=%h, expected all 0",
               busy, lu_valid, lu_hit, lu_content);
    end
    step(z);
  endtask

  function automatic op_t op_lk(input logic [DIDW-1:0] d, input logic [PIDW-1:0] p);
    op_t o;
    o = '0; o.lk = 1'b1; o.ld = d; o.lp = p;
    return o;
  endfunction

  function automatic op_t op_up(input logic [DIDW-1:0] d, input logic [PIDW-1:0] p, input logic v);
    op_t o;
    o = '0; o.up = 1'b1; o.ud = d; o.upp = p; o.uc = mk_pc(v);
    return o;
  endfunction

  function automatic op_t op_fl(input logic dv, input logic pv,
                                input logic [DIDW-1:0] d, input logic [PIDW-1:0] p);
    op_t o;
    o = '0; o.fl = 1'b1; o.fdv = dv; o.fpv = pv; o.fd = d; o.fp = p;
    return o;
  endfunction

  initial begin
    op_t o;
    rst = 1'b1;
    do_reset();

    // basic miss / insert / hit / ta.v=0 drop
    step(op_lk(24'd5, 20'd3));
    step(op_up(24'd5, 20'd3, 1'b1));
    step(op_lk(24'd5, 20'd3));
    step(op_up(24'd6, 20'd1, 1'b0));
    step(op_lk(24'd6, 20'd1));

    // three tags into set 0; hit on the first protects it from eviction
    step(op_up(24'd16, 20'd0, 1'b1));
    step(op_up(24'd16, 20'd4, 1'b1));
    step(op_lk(24'd16, 20'd0));
    step(op_up(24'd16, 20'd8, 1'b1));
    step(op_lk(24'd16, 20'd0));
    step(op_lk(24'd16, 20'd4));
    step(op_lk(24'd16, 20'd8));
    step(op_up(24'd16, 20'd0, 1'b1));
    step(op_lk(24'd16, 20'd0));
    step(op_lk(24'd16, 20'd8));

    // DID sweep: 6 entries DID=7, 2 entries DID=9
    for (int p = 0; p < 6; p++) step(op_up(24'd7, 20'(p), 1'b1));
    step(op_up(24'd9, 20'd0, 1'b1));
    step(op_up(24'd9, 20'd1, 1'b1));
    step(op_fl(1'b1, 1'b0, 24'd7, 20'd0));
    for (int c = 0; c < 4; c++) begin
      o = op_lk(24'd9, 20'd0);
      o.up = 1'b1; o.ud = 24'd9; o.upp = 20'd3; o.uc = mk_pc(1'b1);
      o.fl = (c == 1); o.fpv = 1'b0; o.fdv = 1'b0;
      step(o);
    end
    for (int p = 0; p < 6; p++) step(op_lk(24'd7, 20'(p)));
    step(op_lk(24'd9, 20'd0));
    step(op_lk(24'd9, 20'd1));
    step(op_lk(24'd9, 20'd3));

    // DID+PID flush, then global flush
    for (int p = 0; p < 4; p++) step(op_up(24'd7, 20'(p), 1'b1));
    step(op_fl(1'b0, 1'b1, 24'd7, 20'd2));
    for (int p = 0; p < 4; p++) step(op_lk(24'd7, 20'(p)));
    step(op_fl(1'b0, 1'b0, 24'd0, 20'd0));
    step(op_lk(24'd7, 20'd0));
    step(op_lk(24'd9, 20'd1));

    // flush and update together: update dropped
    o = op_fl(1'b0, 1'b1, 24'd1, 20'd1);
    o.up = 1'b1; o.ud = 24'd5; o.upp = 20'd5; o.uc = mk_pc(1'b1);
    step(o);
    step(op_lk(24'd5, 20'd5));

    // reset in the middle of a sweep
    step(op_up(24'd3, 20'd3, 1'b1));
    step(op_fl(1'b1, 1'b0, 24'd3, 20'd0));
    step('0);
    do_reset();
    step(op_lk(24'd3, 20'd3));

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [DIDW-1:0] d;
      logic [PIDW-1:0] p;
      o  = '0;
      d  = 24'h5A0000 | DIDW'($urandom_range(0, 3));
      p  = PIDW'($urandom_range(0, 7)) | (PIDW'($urandom_range(0, 1)) << 16);
      o.lk = $urandom_range(0, 99) < 60; o.ld = d; o.lp = p;
      d  = 24'h5A0000 | DIDW'($urandom_range(0, 3));
      p  = PIDW'($urandom_range(0, 7)) | (PIDW'($urandom_range(0, 1)) << 16);
      o.up = $urandom_range(0, 99) < 45; o.ud = d; o.upp = p;
      o.uc = mk_pc($urandom_range(0, 99) < 85);
      o.fl = $urandom_range(0, 99) < 4;
      o.fpv = $urandom_range(0, 1) == 1;
      o.fdv = $urandom_range(0, 2) != 0;
      o.fd  = 24'h5A0000 | DIDW'($urandom_range(0, 3));
      o.fp  = PIDW'($urandom_range(0, 7));
      o.clr = $urandom_range(0, 99) < 2;
      step(o);
    end

    for (int i = 0; i < 6; i++) step('0);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d lookup results never arrived, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
